// File: rtl/tdm_sram_arbiter.sv
// tdm_sram_arbiter: time-division-multiplexed single-port SRAM shared between
// one CPU port and NCH round-robin graphics read channels. Every 12-MCLK
// window carries one CPU slot (read latch, then optional write) followed by
// one GFX read slot.
module tdm_sram_arbiter #(
    parameter int AW  = 11,
    parameter int DW  = 8,
    parameter int NCH = 2
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_MRST_n,
    input  logic [4:0]        i_EMU_TIMING,
    input  logic              i_CS_n,
    input  logic              i_CPURW,
    input  logic              i_CPULDS_n,
    input  logic [AW-1:0]     i_CPUADDR,
    input  logic [DW-1:0]     i_CPUDIN,
    output logic [DW-1:0]     o_CPUDOUT,
    output logic              o_CPUDOUT_OE,
    input  logic [NCH-1:0]    i_GFXREQ,
    input  logic [NCH*AW-1:0] i_GFXADDR,
    output logic [NCH*DW-1:0] o_GFXDATA,
    output logic [NCH-1:0]    o_GFXVALID
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CPU_ADDR,
        ST_CPU_RDEND,
        ST_CPU_LATCH,
        ST_CPU_WR,
        ST_CPU_WREND,
        ST_GFX_ADDR,
        ST_GFX_RDEND,
        ST_GFX_LATCH
    } state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     cpu_dout_q, cpu_dout_d;
    logic [NCH*DW-1:0] gfx_data_q, gfx_data_d;
    logic [NCH-1:0]    gfx_valid_q, gfx_valid_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic              gfx_pend_q, gfx_pend_d;

    logic              gfx_found;
    logic [GW-1:0]     gfx_sel;

    logic [DW-1:0]     mem [2**AW];
    logic [DW-1:0]     ram_rdata;

    // Storage array: write and synchronous read are both qualified by the registered strobes.
    always_ff @(posedge i_EMU_MCLK) begin
        if (wr_q) begin
            mem[addr_q] <= wdata_q;
        end
        if (rd_q) begin
            ram_rdata <= mem[addr_q];
        end
    end

    // Decode the pixel parity and MCLK phase into the slot for the next cycle; bit 4 is ignored.
    always_comb begin
        state_d = ST_IDLE;
        case ({i_EMU_TIMING[3], i_EMU_TIMING[2:0]})
            4'b1_101: state_d = ST_CPU_ADDR;
            4'b0_000: state_d = ST_CPU_RDEND;
            4'b0_010: state_d = ST_CPU_LATCH;
            4'b0_011: state_d = ST_CPU_WR;
            4'b0_100: state_d = ST_CPU_WREND;
            4'b0_101: state_d = ST_GFX_ADDR;
            4'b1_000: state_d = ST_GFX_RDEND;
            4'b1_001: state_d = ST_GFX_LATCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Round-robin search starting one past the last granted channel, wrapping.
    always_comb begin
        int idx;
        gfx_found = 1'b0;
        gfx_sel   = '0;
        idx       = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_grant_q) + i) % NCH;
            if (!gfx_found && i_GFXREQ[idx]) begin
                gfx_found = 1'b1;
                gfx_sel   = GW'(idx);
            end
        end
    end

    // Slot actions: strobes are one-cycle pulses, latches hold unless their slot fires.
    always_comb begin
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_dout_d   = cpu_dout_q;
        gfx_data_d   = gfx_data_q;
        gfx_valid_d  = '0;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        gfx_pend_d   = gfx_pend_q;
        case (state_q)
            ST_CPU_ADDR: begin
                addr_d = i_CPUADDR;
                rd_d   = 1'b1;
            end
            ST_CPU_LATCH: begin
                cpu_dout_d = ram_rdata;
            end
            ST_CPU_WR: begin
                if (!(i_CS_n | i_CPURW | i_CPULDS_n)) begin
                    wdata_d = i_CPUDIN;
                    wr_d    = 1'b1;
                end
            end
            ST_GFX_ADDR: begin
                gfx_pend_d = gfx_found;
                if (gfx_found) begin
                    addr_d       = i_GFXADDR[int'(gfx_sel)*AW +: AW];
                    rd_d         = 1'b1;
                    gnt_d        = gfx_sel;
                    last_grant_d = gfx_sel;
                end
            end
            ST_GFX_LATCH: begin
                if (gfx_pend_q) begin
                    gfx_data_d[int'(gnt_q)*DW +: DW] = ram_rdata;
                    gfx_valid_d[gnt_q]               = 1'b1;
                    gfx_pend_d                       = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Control and output registers; reset drops any strobe in flight at once.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
        if (!i_EMU_MRST_n) begin
            state_q      <= ST_IDLE;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_dout_q   <= '0;
            gfx_data_q   <= '0;
            gfx_valid_q  <= '0;
            last_grant_q <= GW'(NCH - 1);
            gnt_q        <= '0;
            gfx_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_dout_q   <= cpu_dout_d;
            gfx_data_q   <= gfx_data_d;
            gfx_valid_q  <= gfx_valid_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            gfx_pend_q   <= gfx_pend_d;
        end
    end

    assign o_CPUDOUT    = cpu_dout_q;
    assign o_CPUDOUT_OE = ~i_CS_n & i_CPURW & ~i_CPULDS_n;
    assign o_GFXDATA    = gfx_data_q;
    assign o_GFXVALID   = gfx_valid_q;

endmodule

// File: tb/tb_tdm_sram_arbiter.sv
// tb_tdm_sram_arbiter: directed checks of the TDM SRAM arbiter with two GFX channels.
module tb_tdm_sram_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rstN;
    logic [4:0]        timing;
    logic              csN, cpuRw, ldsN;
    logic [AW-1:0]     cpuAddr;
    logic [DW-1:0]     cpuDin;
    logic [DW-1:0]     cpuDout;
    logic              cpuOe;
    logic [NCH-1:0]    gfxReq;
    logic [NCH*AW-1:0] gfxAddr;
    logic [NCH*DW-1:0] gfxData;
    logic [NCH-1:0]    gfxValid;

    int passes = 0;
    int total  = 0;
    int vcnt0, vcnt1, multi;

    tdm_sram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH)) dut (
        .i_EMU_MCLK   (clk),
        .i_EMU_MRST_n (rstN),
        .i_EMU_TIMING (timing),
        .i_CS_n       (csN),
        .i_CPURW      (cpuRw),
        .i_CPULDS_n   (ldsN),
        .i_CPUADDR    (cpuAddr),
        .i_CPUDIN     (cpuDin),
        .o_CPUDOUT    (cpuDout),
        .o_CPUDOUT_OE (cpuOe),
        .i_GFXREQ     (gfxReq),
        .i_GFXADDR    (gfxAddr),
        .o_GFXDATA    (gfxData),
        .o_GFXVALID   (gfxValid)
    );

    // Free-running master clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic cs, input logic rw, input logic lds,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [NCH-1:0] req,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        csN     = cs;
        cpuRw   = rw;
        ldsN    = lds;
        cpuAddr = a;
        cpuDin  = d;
        gfxReq  = req;
        gfxAddr = {a1, a0};
    endtask

    // One 12-slot window; slot 11 always drives pixel1 ph5 so the next window stays aligned.
    task automatic runWindow(input bit oddPhase, input bit dropReq, input int rstSlot);
        logic [2:0] ph;
        logic       par;
        vcnt0 = 0;
        vcnt1 = 0;
        multi = 0;
        for (int s = 0; s < 12; s++) begin
            par = (s >= 6);
            ph  = 3'(s % 6);
            if (oddPhase && s < 11) ph = (s % 2 == 0) ? 3'd6 : 3'd7;
            timing = {(s % 3 == 0), par, ph};
            if (dropReq && s == 7) gfxReq = '0;
            @(posedge clk);
            #1;
            vcnt0 += int'(gfxValid[0]);
            vcnt1 += int'(gfxValid[1]);
            if (gfxValid == 2'b11) multi++;
            if (s == rstSlot) begin
                rstN = 1'b0;
                #1;
                checkOutput("rst_async_cpudout", 32'(cpuDout), 32'h0);
                checkOutput("rst_async_gfxdata", 32'(gfxData), 32'h0);
                checkOutput("rst_async_gfxvalid", 32'(gfxValid), 32'h0);
                return;
            end
        end
    endtask

    task automatic releaseAndAlign();
        timing = 5'b01101;
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN   = 1'b0;
        timing = 5'b01101;
        applyStimulus(1, 1, 1, '0, '0, 2'b00, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_cpudout", 32'(cpuDout), 32'h0);
        checkOutput("reset_gfxdata", 32'(gfxData), 32'h0);
        checkOutput("reset_gfxvalid", 32'(gfxValid), 32'h0);

        applyStimulus(0, 1, 0, '0, '0, 2'b00, '0, '0);
        #1 checkOutput("oe_read", 32'(cpuOe), 32'h1);
        csN = 1'b1;
        #1 checkOutput("oe_cs_off", 32'(cpuOe), 32'h0);
        csN = 1'b0; ldsN = 1'b1;
        #1 checkOutput("oe_lds_off", 32'(cpuOe), 32'h0);

        releaseAndAlign();

        applyStimulus(0, 0, 0, 11'h123, 8'hA5, 2'b00, '0, '0);
        runWindow(0, 0, -1);
        checkOutput("write_no_valid", 32'(vcnt0 + vcnt1), 32'h0);
        applyStimulus(0, 1, 0, 11'h123, 8'h00, 2'b00, '0, '0);
        runWindow(0, 0, -1);
        checkOutput("cpu_read_a5", 32'(cpuDout), 32'hA5);
        checkOutput("cpu_read_oe", 32'(cpuOe), 32'h1);

        applyStimulus(0, 0, 0, 11'h011, 8'h11, 2'b00, '0, '0);
        runWindow(0, 0, -1);
        applyStimulus(0, 0, 0, 11'h022, 8'h22, 2'b00, '0, '0);
        runWindow(0, 0, -1);
        applyStimulus(0, 0, 0, 11'h040, 8'h00, 2'b00, '0, '0);
        runWindow(0, 0, -1);

        applyStimulus(1, 1, 1, 11'h123, 8'h00, 2'b11, 11'h011, 11'h022);
        runWindow(0, 0, -1);
        checkOutput("rr1_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h1);
        checkOutput("rr1_ch0_data", 32'(gfxData[7:0]), 32'h11);
        runWindow(0, 0, -1);
        checkOutput("rr2_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h4);
        checkOutput("rr2_ch1_data", 32'(gfxData[15:8]), 32'h22);
        runWindow(0, 0, -1);
        checkOutput("rr3_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h1);
        checkOutput("rr3_multi", 32'(multi), 32'h0);
        checkOutput("idle_cpu_latch", 32'(cpuDout), 32'hA5);

        applyStimulus(1, 1, 1, 11'h123, 8'h00, 2'b10, 11'h123, 11'h022);
        for (int w = 0; w < 3; w++) begin
            runWindow(0, 0, -1);
            checkOutput($sformatf("ch1only_valid_w%0d", w), 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h4);
            checkOutput($sformatf("ch1only_ch0_hold_w%0d", w), 32'(gfxData[7:0]), 32'h11);
        end

        applyStimulus(0, 0, 0, 11'h040, 8'h5A, 2'b01, 11'h040, 11'h022);
        runWindow(0, 0, -1);
        checkOutput("same_win_cpu_old", 32'(cpuDout), 32'h00);
        checkOutput("same_win_gfx_new", 32'(gfxData[7:0]), 32'h5A);
        checkOutput("same_win_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h1);

        applyStimulus(1, 1, 1, 11'h123, 8'h00, 2'b10, 11'h011, 11'h040);
        runWindow(0, 1, -1);
        checkOutput("drop_req_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h4);
        checkOutput("drop_req_data", 32'(gfxData[15:8]), 32'h5A);

        applyStimulus(1, 1, 1, 11'h123, 8'h00, 2'b00, 11'h011, 11'h022);
        runWindow(0, 0, -1);
        checkOutput("noreq_valid", 32'(vcnt0 + vcnt1), 32'h0);
        checkOutput("noreq_data_hold", 32'(gfxData), 32'h5A5A);
        gfxReq = 2'b11;
        runWindow(0, 0, -1);
        checkOutput("noreq_ptr_kept", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h1);
        checkOutput("noreq_ptr_data", 32'(gfxData[7:0]), 32'h11);

        applyStimulus(0, 1, 0, 11'h040, 8'h00, 2'b11, 11'h011, 11'h022);
        runWindow(1, 0, -1);
        checkOutput("phase67_valid", 32'(vcnt0 + vcnt1), 32'h0);
        checkOutput("phase67_cpu_hold", 32'(cpuDout), 32'hA5);
        checkOutput("phase67_gfx_hold", 32'(gfxData), 32'h5A11);
        runWindow(0, 0, -1);
        checkOutput("resume_cpu", 32'(cpuDout), 32'h5A);
        checkOutput("resume_gfx_valid", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h4);
        checkOutput("resume_gfx_data", 32'(gfxData[15:8]), 32'h22);

        applyStimulus(0, 0, 0, 11'h123, 8'hFF, 2'b00, 11'h011, 11'h022);
        runWindow(0, 0, 4);
        releaseAndAlign();
        applyStimulus(0, 1, 0, 11'h123, 8'h00, 2'b11, 11'h011, 11'h022);
        runWindow(0, 0, -1);
        checkOutput("rst_word_unchanged", 32'(cpuDout), 32'hA5);
        checkOutput("rst_ptr_ch0_first", 32'({vcnt1[1:0], vcnt0[1:0]}), 32'h1);
        checkOutput("rst_ch1_zero", 32'(gfxData[15:8]), 32'h00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
